// File: rtl/addsub_pkg.sv
// Shared types and constants for the shared 4-bit add/subtract arbiter.
package addsub_pkg;

   localparam int ADD_W = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

endpackage

// File: rtl/adder_sub.sv
// Ripple 4-bit adder/subtractor: subtract is A + ~B + 1, so cout=1 means no borrow.
module adder_sub
   import addsub_pkg::*;
(
   input  logic [ADD_W-1:0] a,
   input  logic [ADD_W-1:0] b,
   input  logic             mode,
   output logic [ADD_W-1:0] sum,
   output logic             cout
);

   logic [ADD_W:0] full;

   assign full = {1'b0, a} + {1'b0, b ^ {ADD_W{mode}}} + {{ADD_W{1'b0}}, mode};
   assign {cout, sum} = full;

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one adder_sub between NREQ requesters; one operation
// in flight at a time (IDLE -> EXEC -> RESP), result tagged with the owner index.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [ADD_W*NREQ-1:0] req_a,
   input  logic [ADD_W*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]       req_mode,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [ADD_W-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_ovf,
   output logic                  busy
);

   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [NREQ-1:0]  rot;
   logic             found;
   logic [IDW-1:0]   pick;
   logic [IDW:0]     gsum;
   logic [IDW:0]     nsum;
   logic [IDW-1:0]   grant;
   logic [IDW-1:0]   next_ptr;
   logic             take;
   logic [ADD_W-1:0] sel_a, sel_b;
   logic             sel_mode;
   logic [ADD_W-1:0] op_a, op_b;
   logic             op_mode;
   logic [IDW-1:0]   op_id;
   logic [ADD_W-1:0] sum;
   logic             cout;
   logic             ovf;

   // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then unrotate.
   always_comb begin
      rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = req_valid[(i + int'(rr_ptr)) % NREQ];
      end
   end

   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            pick  = IDW'(i);
         end
      end
   end

   assign gsum     = {1'b0, pick} + {1'b0, rr_ptr};
   assign grant    = (gsum >= NREQ_W) ? IDW'(gsum - NREQ_W) : gsum[IDW-1:0];
   assign nsum     = {1'b0, grant} + {{IDW{1'b0}}, 1'b1};
   assign next_ptr = (nsum >= NREQ_W) ? IDW'(nsum - NREQ_W) : nsum[IDW-1:0];

   assign take = (state == IDLE) && found;

   always_comb begin
      req_ready = '0;
      if (take) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      sel_a    = '0;
      sel_b    = '0;
      sel_mode = MODE_ADD;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == IDW'(i)) begin
            sel_a    = req_a[ADD_W*i +: ADD_W];
            sel_b    = req_b[ADD_W*i +: ADD_W];
            sel_mode = req_mode[i];
         end
      end
   end

   adder_sub u_adder_sub (
      .a    (op_a),
      .b    (op_b),
      .mode (op_mode),
      .sum  (sum),
      .cout (cout)
   );

   // Signed overflow uses the original B, before the subtract inversion.
   assign ovf = (op_mode == MODE_SUB)
              ? ((op_a[ADD_W-1] != op_b[ADD_W-1]) && (sum[ADD_W-1] != op_a[ADD_W-1]))
              : ((op_a[ADD_W-1] == op_b[ADD_W-1]) && (sum[ADD_W-1] != op_a[ADD_W-1]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_mode   <= MODE_ADD;
         op_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_ovf   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  op_a    <= sel_a;
                  op_b    <= sel_b;
                  op_mode <= sel_mode;
                  op_id   <= grant;
                  rr_ptr  <= next_ptr;
                  busy    <= 1'b1;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               rsp_sum   <= sum;
               rsp_cout  <= cout;
               rsp_ovf   <= ovf;
               rsp_id    <= op_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed-vector bench for addsub_arbiter with NREQ=4.
module tb_addsub_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [NREQ-1:0]   req_mode;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [3:0]        rsp_sum;
   logic              rsp_cout;
   logic              rsp_ovf;
   logic              busy;

   int checks = 0;
   int errors = 0;

   addsub_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_mode  (req_mode),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b, input logic m);
      req_a[4*idx +: 4] = a;
      req_b[4*idx +: 4] = b;
      req_mode[idx]     = m;
   endtask

   // One full operation with rsp_ready high; called right after a negedge.
   task automatic run_op(input string tag, input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic m, input logic [3:0] esum, input logic ecout, input logic eovf);
      set_req(idx, a, b, m);
      req_valid = '0;
      req_valid[idx] = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
      @(negedge clk);
      req_valid = '0;
      chk({tag, "_exec_vld"}, 32'(rsp_valid), 0);
      chk({tag, "_exec_busy"}, 32'(busy), 1);
      @(negedge clk);
      chk({tag, "_vld"}, 32'(rsp_valid), 1);
      chk({tag, "_sum"}, 32'(rsp_sum), 32'(esum));
      chk({tag, "_cout"}, 32'(rsp_cout), 32'(ecout));
      chk({tag, "_ovf"}, 32'(rsp_ovf), 32'(eovf));
      chk({tag, "_id"}, 32'(rsp_id), 32'(idx));
      @(negedge clk);
      chk({tag, "_done"}, 32'(rsp_valid), 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_mode  = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_vld", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sum", 32'(rsp_sum), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_ptr", 32'(dut.rr_ptr), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 0);

      run_op("add3p5", 0, 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
      // 9-3 is -7-3 signed: out of range, so overflow is set.
      run_op("sub9m3", 2, 4'd9, 4'd3, 1'b1, 4'd6, 1'b1, 1'b1);
      run_op("sub3m5", 2, 4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0);
      run_op("sub7m8", 2, 4'd7, 4'd8, 1'b1, 4'd15, 1'b0, 1'b1);

      // Backpressure on requester 1 while requester 0 waits.
      set_req(1, 4'd1, 4'd2, 1'b0);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      chk("bp_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = 4'b0001;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld", 32'(rsp_valid), 1);
         chk("bp_sum", 32'(rsp_sum), 3);
         chk("bp_id", 32'(rsp_id), 1);
         chk("bp_cout_ovf", 32'({rsp_cout, rsp_ovf}), 0);
         chk("bp_rdy0", 32'(req_ready), 0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      @(negedge clk);
      chk("bp_rel1", 32'(rsp_valid), 0);
      @(negedge clk);
      chk("bp_rel2", 32'(rsp_valid), 0);
      chk("bp_busy", 32'(busy), 0);

      // Reset during EXEC on requester 3.
      set_req(3, 4'd5, 4'd1, 1'b0);
      req_valid = 4'b1000;
      #1;
      chk("mr_ready", 32'(req_ready), 32'h8);
      @(negedge clk);
      req_valid = '0;
      chk("mr_exec", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy", 32'(busy), 0);
      chk("mr_vld", 32'(rsp_valid), 0);
      chk("mr_sum", 32'(rsp_sum), 0);
      chk("mr_id", 32'(rsp_id), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("mr_norsp", 32'(rsp_valid), 0);
      end

      // Fairness: all valid, expect grants 0,1,2,3,0,1.
      for (int i = 0; i < NREQ; i++) set_req(i, 4'(i), 4'd1, 1'b0);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
         @(negedge clk);
         @(negedge clk);
         chk("rr_id", 32'(rsp_id), 32'(k % 4));
         chk("rr_sum", 32'(rsp_sum), 32'((k % 4) + 1));
         @(negedge clk);
      end
      req_valid = '0;
      @(negedge clk);

      // Sparse: only 3, then only 1.
      set_req(3, 4'd2, 4'd2, 1'b0);
      req_valid = 4'b1000;
      #1;
      chk("sp_g3", 32'(req_ready), 32'h8);
      @(negedge clk);
      req_valid = '0;
      chk("sp_ptr0", 32'(dut.rr_ptr), 0);
      repeat (2) @(negedge clk);
      set_req(1, 4'd6, 4'd1, 1'b1);
      req_valid = 4'b0010;
      #1;
      chk("sp_g1", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = '0;
      chk("sp_ptr2", 32'(dut.rr_ptr), 2);
      @(negedge clk);
      chk("sp_sum", 32'(rsp_sum), 5);
      chk("sp_id", 32'(rsp_id), 1);
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      chk("sp_next", 32'(req_ready), 32'h4);
      req_valid = '0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
